// File: rtl/multdiv_issue_if.sv
// Handshake bundle between the DX stage, the multdiv unit and writeback
// for the mult/div issue latch.
interface multdiv_issue_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic [31:0]      in_IR;
    logic             md_rdy;
    logic [WIDTH-1:0] md_result;
    logic             md_exception;
    logic             wb_ack;
    logic [WIDTH-1:0] out_A;
    logic [WIDTH-1:0] out_B;
    logic [31:0]      out_IR;
    logic             out_ctrl_MULT;
    logic             out_ctrl_DIV;
    logic             stall;
    logic             busy;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic [4:0]       res_rd;
    logic             res_exception;
    logic             timeout;

    modport slave (
        input  in_A, in_B, in_IR, md_rdy, md_result, md_exception, wb_ack,
        output out_A, out_B, out_IR, out_ctrl_MULT, out_ctrl_DIV, stall, busy,
               res_valid, res_data, res_rd, res_exception, timeout
    );

    modport master (
        output in_A, in_B, in_IR, md_rdy, md_result, md_exception, wb_ack,
        input  out_A, out_B, out_IR, out_ctrl_MULT, out_ctrl_DIV, stall, busy,
               res_valid, res_data, res_rd, res_exception, timeout
    );
endinterface

// File: rtl/multdiv_issue.sv
// DX-stage mult/div operand latch: issues a start pulse, tracks the multdiv
// unit through completion with a watchdog, and holds the result for writeback.
module multdiv_issue #(
    parameter int         WIDTH      = 32,
    parameter logic [4:0] OP_ALU     = 5'd0,
    parameter logic [4:0] MULT_ALUOP = 5'd6,
    parameter logic [4:0] DIV_ALUOP  = 5'd7,
    parameter int         TIMEOUT    = 64
) (
    input  logic              clock,
    input  logic              reset,
    multdiv_issue_if.slave    bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, data_q;
    logic [31:0]      ir_q;
    logic             mult_q, div_q, valid_q, exc_q, tmo_q;
    logic [4:0]       rd_q;
    logic             is_md, accept;

    assign is_md  = (bus.in_IR[31:27] == OP_ALU) &&
                    ((bus.in_IR[6:2] == MULT_ALUOP) || (bus.in_IR[6:2] == DIV_ALUOP));
    assign accept = (state == IDLE) || ((state == DONE) && bus.wb_ack);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ir_q    <= '0;
            mult_q  <= 1'b0;
            div_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            rd_q    <= '0;
            exc_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            mult_q <= 1'b0;
            div_q  <= 1'b0;
            // Capture and pulse selection are shared by IDLE and the back-to-back DONE path;
            // the pulse is registered here so it is high exactly while in START.
            if (is_md && accept) begin
                a_q    <= bus.in_A;
                b_q    <= bus.in_B;
                ir_q   <= bus.in_IR;
                mult_q <= (bus.in_IR[6:2] == MULT_ALUOP);
                div_q  <= (bus.in_IR[6:2] != MULT_ALUOP);
            end
            unique case (state)
                IDLE: if (is_md) state <= START;
                START: begin
                    cnt   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (bus.md_rdy) begin
                        data_q  <= bus.md_result;
                        exc_q   <= bus.md_exception;
                        tmo_q   <= 1'b0;
                        rd_q    <= ir_q[26:22];
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else if (cnt == LIMIT) begin
                        data_q  <= '0;
                        exc_q   <= 1'b1;
                        tmo_q   <= 1'b1;
                        rd_q    <= ir_q[26:22];
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: if (bus.wb_ack) begin
                    valid_q <= 1'b0;
                    state   <= is_md ? START : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall         = is_md && !accept;
    assign bus.busy          = (state != IDLE);
    assign bus.out_A         = a_q;
    assign bus.out_B         = b_q;
    assign bus.out_IR        = ir_q;
    assign bus.out_ctrl_MULT = mult_q;
    assign bus.out_ctrl_DIV  = div_q;
    assign bus.res_valid     = valid_q;
    assign bus.res_data      = data_q;
    assign bus.res_rd        = rd_q;
    assign bus.res_exception = exc_q;
    assign bus.timeout       = tmo_q;
endmodule

// File: tb/tb_multdiv_issue.sv
// Bench for multdiv_issue: table of instruction classes, randomized
// transactions against a transaction-level model, and hand-written corner sequences.
module tb_multdiv_issue;
    localparam int W   = 32;
    localparam int TMO = 8;
    localparam logic [31:0] NOP = 32'h0;

    logic clock = 1'b0;
    logic reset = 1'b0;

    multdiv_issue_if #(.WIDTH(W)) bus();

    multdiv_issue #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [31:0] lat_A = '0, lat_B = '0, lat_IR = '0;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  aluop;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        bit          exp_md;
    } vec_t;

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] aluop, input logic [14:0] fill);
        return {op, rd, fill, aluop, 2'b00};
    endfunction

    function automatic bit ref_is_md(input logic [31:0] ir);
        return (ir[31:27] == 5'd0) && (ir[6:2] == 5'd6 || ir[6:2] == 5'd7);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_nonmd(input logic [31:0] ir);
        bus.in_IR = ir;
        bus.in_A  = $urandom;
        bus.in_B  = $urandom;
        #1 chk("nonmd_stall", bus.stall, 1'b0);
        tick();
        chk("nonmd_busy", bus.busy, 1'b0);
        chk("nonmd_mult", bus.out_ctrl_MULT, 1'b0);
        chk("nonmd_div", bus.out_ctrl_DIV, 1'b0);
        chk("nonmd_outA", bus.out_A, lat_A);
        chk("nonmd_outB", bus.out_B, lat_B);
        chk("nonmd_outIR", bus.out_IR, lat_IR);
        bus.in_IR = NOP;
    endtask

    // One full transaction from IDLE back to IDLE; lat > TMO means the unit never answers.
    task automatic run_op(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                          input int unsigned lat, input logic [31:0] res, input logic exc,
                          input int unsigned ack_dly, input bit poke);
        bit          is_mult, timed_out;
        int unsigned nb;
        logic [31:0] e_data;
        is_mult   = (ir[6:2] == 5'd6);
        timed_out = (lat > TMO);
        nb        = timed_out ? TMO : lat;
        e_data    = timed_out ? 32'h0 : res;

        bus.in_IR = ir; bus.in_A = a; bus.in_B = b;
        #1 chk("issue_stall", bus.stall, 1'b0);
        tick();
        bus.in_IR = NOP; bus.in_A = $urandom; bus.in_B = $urandom;
        bus.md_rdy = poke; bus.md_result = $urandom;
        chk("start_outA", bus.out_A, a);
        chk("start_outB", bus.out_B, b);
        chk("start_outIR", bus.out_IR, ir);
        chk("start_mult", bus.out_ctrl_MULT, is_mult);
        chk("start_div", bus.out_ctrl_DIV, !is_mult);
        chk("start_busy", bus.busy, 1'b1);
        chk("start_valid", bus.res_valid, 1'b0);
        lat_A = a; lat_B = b; lat_IR = ir;
        tick();
        chk("busy_mult0", bus.out_ctrl_MULT, 1'b0);
        chk("busy_div0", bus.out_ctrl_DIV, 1'b0);
        for (int k = 1; k <= int'(nb); k++) begin
            bus.md_rdy       = (k == int'(lat));
            bus.md_result    = (k == int'(lat)) ? res : $urandom;
            bus.md_exception = (k == int'(lat)) ? exc : 1'b0;
            if (poke) begin
                bus.in_IR = ir;
                #1 chk("busy_stall", bus.stall, 1'b1);
            end
            chk("busy_valid", bus.res_valid, 1'b0);
            tick();
            bus.md_rdy = 1'b0; bus.in_IR = NOP;
        end
        chk("done_valid", bus.res_valid, 1'b1);
        chk("done_data", bus.res_data, e_data);
        chk("done_exc", bus.res_exception, timed_out ? 1'b1 : exc);
        chk("done_tmo", bus.timeout, timed_out);
        chk("done_rd", bus.res_rd, ir[26:22]);
        for (int d = 0; d < int'(ack_dly); d++) begin
            bus.md_rdy = $urandom_range(0, 1);
            bus.md_result = $urandom;
            if (poke) begin
                bus.in_IR = ir;
                #1 chk("done_stall", bus.stall, 1'b1);
            end
            tick();
            bus.in_IR = NOP;
            chk("hold_valid", bus.res_valid, 1'b1);
            chk("hold_data", bus.res_data, e_data);
        end
        bus.md_rdy = 1'b0; bus.wb_ack = 1'b1;
        #1 chk("ack_stall", bus.stall, 1'b0);
        tick();
        bus.wb_ack = 1'b0;
        chk("ack_valid", bus.res_valid, 1'b0);
        chk("ack_busy", bus.busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[8];
        logic [31:0] ir1, ir2, r;
        logic [4:0]  rd;

        tbl[0] = '{5'd0, 5'd6, 5'd3,  32'd7,   32'd6,  1'b1};
        tbl[1] = '{5'd0, 5'd7, 5'd17, 32'd100, 32'd7,  1'b1};
        tbl[2] = '{5'd0, 5'd0, 5'd4,  32'd11,  32'd12, 1'b0};
        tbl[3] = '{5'd5, 5'd6, 5'd4,  32'd13,  32'd14, 1'b0};
        tbl[4] = '{5'd1, 5'd7, 5'd4,  32'd15,  32'd16, 1'b0};
        tbl[5] = '{5'd0, 5'd8, 5'd4,  32'd17,  32'd18, 1'b0};
        tbl[6] = '{5'd0, 5'd6, 5'd0,  32'hFFFF_FFFF, 32'd2, 1'b1};
        tbl[7] = '{5'd31, 5'd6, 5'd4, 32'd19,  32'd20, 1'b0};

        bus.in_A = '0; bus.in_B = '0; bus.in_IR = NOP;
        bus.md_rdy = 1'b0; bus.md_result = '0; bus.md_exception = 1'b0; bus.wb_ack = 1'b0;

        reset = 1'b0;
        tick(); tick();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_valid", bus.res_valid, 1'b0);
        chk("rst_outA", bus.out_A, 32'h0);
        chk("rst_mult", bus.out_ctrl_MULT, 1'b0);
        chk("rst_tmo", bus.timeout, 1'b0);
        reset = 1'b1;

        // Test-plan MULT 7*6 and DIV by zero
        run_op(mk_ir(5'd0, 5'd9, 5'd6, 15'h1234), 32'd7, 32'd6, 3, 32'd42, 1'b0, 2, 1'b0);
        run_op(mk_ir(5'd0, 5'd5, 5'd7, 15'h0), 32'd100, 32'd0, 4, 32'd0, 1'b1, 0, 1'b0);

        foreach (tbl[i]) begin
            ir1 = mk_ir(tbl[i].op, tbl[i].rd, tbl[i].aluop, 15'(i));
            if (tbl[i].exp_md)
                run_op(ir1, tbl[i].a, tbl[i].b, 2, tbl[i].a * tbl[i].b, 1'b0, 1, 1'b0);
            else
                apply_nonmd(ir1);
        end

        // Watchdog boundary: answer on the last allowed cycle, then no answer at all
        run_op(mk_ir(5'd0, 5'd7, 5'd6, 15'h0), 32'd3, 32'd4, TMO, 32'd12, 1'b0, 0, 1'b0);
        run_op(mk_ir(5'd0, 5'd8, 5'd7, 15'h0), 32'd3, 32'd4, TMO + 1, 32'd99, 1'b0, 1, 1'b1);

        // Back-to-back: second MULT stalls through BUSY/DONE and is captured with wb_ack
        ir1 = mk_ir(5'd0, 5'd10, 5'd6, 15'h0);
        ir2 = mk_ir(5'd0, 5'd11, 5'd6, 15'h7);
        bus.in_IR = ir1; bus.in_A = 32'd21; bus.in_B = 32'd2;
        tick();
        tick();
        bus.in_IR = ir2; bus.in_A = 32'd5; bus.in_B = 32'd9;
        bus.md_rdy = 1'b1; bus.md_result = 32'd42;
        #1 chk("b2b_stall_busy", bus.stall, 1'b1);
        tick();
        bus.md_rdy = 1'b0;
        chk("b2b_stall_done", bus.stall, 1'b1);
        chk("b2b_data1", bus.res_data, 32'd42);
        tick();
        chk("b2b_hold_outA", bus.out_A, 32'd21);
        bus.wb_ack = 1'b1;
        #1 chk("b2b_stall_ack", bus.stall, 1'b0);
        tick();
        bus.wb_ack = 1'b0; bus.in_IR = NOP;
        chk("b2b_outA2", bus.out_A, 32'd5);
        chk("b2b_outB2", bus.out_B, 32'd9);
        chk("b2b_mult2", bus.out_ctrl_MULT, 1'b1);
        chk("b2b_valid_clr", bus.res_valid, 1'b0);
        chk("b2b_busy", bus.busy, 1'b1);
        tick();
        bus.md_rdy = 1'b1; bus.md_result = 32'd45;
        tick();
        bus.md_rdy = 1'b0;
        chk("b2b_data2", bus.res_data, 32'd45);
        chk("b2b_rd2", bus.res_rd, 5'd11);
        bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        chk("b2b_idle", bus.busy, 1'b0);
        lat_A = 32'd5; lat_B = 32'd9; lat_IR = ir2;

        // Reset during BUSY, then a late md_rdy must be ignored
        bus.in_IR = mk_ir(5'd0, 5'd12, 5'd7, 15'h0); bus.in_A = 32'd8; bus.in_B = 32'd2;
        tick();
        bus.in_IR = NOP;
        tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rstmid_busy", bus.busy, 1'b0);
        chk("rstmid_outA", bus.out_A, 32'h0);
        chk("rstmid_outIR", bus.out_IR, 32'h0);
        bus.md_rdy = 1'b1; bus.md_result = 32'd4;
        tick();
        bus.md_rdy = 1'b0;
        chk("rstmid_valid", bus.res_valid, 1'b0);
        chk("rstmid_busy2", bus.busy, 1'b0);
        lat_A = '0; lat_B = '0; lat_IR = '0;

        // Randomized transactions against the transaction-level model
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b, ir;
            int unsigned lat;
            bit          mul;
            a = $urandom; b = $urandom_range(0, 20);
            mul = $urandom_range(0, 1);
            rd = 5'($urandom);
            ir = mk_ir(5'd0, rd, mul ? 5'd6 : 5'd7, 15'($urandom));
            lat = $urandom_range(1, TMO + 3);
            if (mul)           r = a * b;
            else if (b != 0)   r = a / b;
            else               r = 32'h0;
            run_op(ir, a, b, lat, r, (!mul && b == 0), $urandom_range(0, 3), $urandom_range(0, 1));
            ir = $urandom;
            if (!ref_is_md(ir)) apply_nonmd(ir);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multdiv_issue.md
Name: multdiv_issue

Overview:
- Parametrised successor to the mult/div operand latch in the DX stage.
- Latches operands and instruction for a MULT/DIV and issues a one-cycle start pulse to the multi-cycle multdiv unit.
- Tracks the operation through completion and holds the result for writeback until it is acknowledged.
- Stalls the pipeline when a second MULT/DIV arrives while the unit is occupied; a watchdog aborts hung operations.

Parameters:
- WIDTH, 32: operand and result width.
- OP_ALU, 5'd0: opcode (IR[31:27]) value for ALU-class instructions.
- MULT_ALUOP, 5'd6: ALU op (IR[6:2]) value for MULT.
- DIV_ALUOP, 5'd7: ALU op value for DIV.
- TIMEOUT, 64: BUSY-cycle limit before abort; must be ≥2. Counter width is clog2(TIMEOUT+1).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_A  in  WIDTH  rs operand from DX.
- in_B  in  WIDTH  rt operand from DX.
- in_IR  in  32  DX instruction.
- md_rdy  in  1  multdiv unit result-ready pulse.
- md_result  in  WIDTH  multdiv unit result, valid when md_rdy=1.
- md_exception  in  1  multdiv unit exception (overflow or div-by-0), valid with md_rdy.
- wb_ack  in  1  writeback has consumed the held result.
- out_A  out  WIDTH  latched operand A.
- out_B  out  WIDTH  latched operand B.
- out_IR  out  32  latched instruction.
- out_ctrl_MULT  out  1  one-cycle start pulse for MULT.
- out_ctrl_DIV  out  1  one-cycle start pulse for DIV.
- stall  out  1  hold the F/D/DX stages (combinational).
- busy  out  1  state is not IDLE.
- res_valid  out  1  held result is available.
- res_data  out  WIDTH  held result.
- res_rd  out  5  destination register, taken from latched IR[26:22].
- res_exception  out  1  result carries an exception.
- timeout  out  1  held result was produced by a watchdog abort.

Behaviour:
- is_md = (in_IR[31:27]==OP_ALU) && (in_IR[6:2]==MULT_ALUOP || in_IR[6:2]==DIV_ALUOP).
- accept = (state==IDLE) || (state==DONE && wb_ack).
- stall = is_md && !accept. No other stall sources.
- Reset (reset==0 at an edge): state=IDLE; all registered outputs and the watchdog counter are 0. An operation in progress is abandoned; a late md_rdy after reset is ignored because the block is in IDLE.
- States: IDLE, START, BUSY, DONE.
- IDLE: on is_md, capture in_A, in_B, in_IR into out_A, out_B, out_IR and go to START. Otherwise hold all state; out_* keep their last values.
- START (exactly 1 cycle):
  - out_ctrl_MULT=1 if latched IR[6:2]==MULT_ALUOP, else out_ctrl_DIV=1. Never both high.
  - Clear the counter and go to BUSY.
  - md_rdy during START is ignored.
- BUSY: counter increments every cycle.
  - md_rdy=1: res_data←md_result, res_exception←md_exception, res_rd←out_IR[26:22], timeout←0, res_valid←1; go to DONE.
  - Otherwise, if counter==TIMEOUT-1: res_data←0, res_exception←1, timeout←1, res_valid←1, res_rd←out_IR[26:22]; go to DONE.
  - If md_rdy and the limit coincide, md_rdy wins.
- DONE: res_* held stable until wb_ack.
  - On wb_ack: clear res_valid. If is_md in the same cycle, capture the new operands and go to START (back-to-back, no bubble); otherwise go to IDLE.
  - md_rdy in DONE or IDLE is ignored.
- Start-to-result latency = unit latency + 1 cycle (START). res_valid rises the cycle after md_rdy.
- res_rd==0 is still presented with res_valid=1; writeback decides whether to discard.
- Non-MD instructions never change state or outputs.
- Start pulses are asserted only in START.
- Watchdog counts only in BUSY; it is not reset by stall.

Test Plan:
- Reset then MULT: hold reset=0 for 2 cycles, release, present IR op 0/aluop 6 with A=7, B=6. Next cycle out_ctrl_MULT=1 for exactly 1 cycle, out_A=7, out_B=6. md_rdy with md_result=42 three cycles later → next cycle res_valid=1, res_data=42, res_rd=IR[26:22]; wb_ack → IDLE, busy=0.
- DIV by zero: aluop 7, B=0, unit returns md_exception=1 → out_ctrl_DIV pulse only (MULT pulse stays 0), res_exception=1, timeout=0.
- Structural stall: a second MULT presented while in BUSY → stall=1 every cycle until DONE with wb_ack. It is then captured in that same cycle and out_ctrl_MULT pulses the following cycle.
- Watchdog: TIMEOUT=8, md_rdy never asserted → after 8 BUSY cycles res_valid=1, res_data=0, res_exception=1, timeout=1. md_rdy coinciding with the 8th cycle → normal result, timeout=0.
- Reset mid-op: reset=0 during BUSY → all outputs 0 next cycle. A subsequent md_rdy=1 is ignored and res_valid stays 0.
- Filtering: an ADD (aluop 0) and an I-type instruction with IR[6:2]=6 but opcode≠0 → no pulses, busy=0, stall=0, out_A/out_B unchanged.
